// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the five-stage CPU pipeline registers.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  // MEM/WB pipeline register contents; load data is kept raw, selection happens downstream.
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memtoreg;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
  } memwb_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Bus bundle between the MEM stage / decode stage / register file and the write-back stage.
interface writeback_stage_if
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic              RegWrite_i;
  logic              MemtoReg_i;
  logic [ADDR_W-1:0] RDaddr_i;
  logic [DATA_W-1:0] ALUdata_i;
  logic [DATA_W-1:0] MEMdata_i;
  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic [DATA_W-1:0] RSdata_i;
  logic [DATA_W-1:0] RTdata_i;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic              RegWrite_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic [CNT_W-1:0]  wb_count_o;

  // Pipeline side: drives the entry and read ports, observes the write port.
  modport master (
    output stall_i, flush_i, valid_i, RegWrite_i, MemtoReg_i, RDaddr_i, ALUdata_i, MEMdata_i,
    output RSaddr_i, RTaddr_i, RSdata_i, RTdata_i,
    input  RSdata_o, RTdata_o, RegWrite_o, RDaddr_o, RDdata_o, wb_count_o
  );

  // Write-back stage side.
  modport slave (
    input  stall_i, flush_i, valid_i, RegWrite_i, MemtoReg_i, RDaddr_i, ALUdata_i, MEMdata_i,
    input  RSaddr_i, RTaddr_i, RSdata_i, RTdata_i,
    output RSdata_o, RTdata_o, RegWrite_o, RDaddr_o, RDdata_o, wb_count_o
  );

endinterface

// File: rtl/wb_bypass.sv
// Single read-port bypass: returns the in-flight write data when the addresses match.
module wb_bypass
  import cpu_pkg::*;
(
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // we_i is already low for r0, so r0 never gets bypassed.
  always_comb begin
    rd_data_o = rd_data_i;
    if (we_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, register file write driver, read bypass and retire counter.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  writeback_stage_if.slave wb
);

  memwb_t            memwb_q, memwb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              reg_we;
  logic [DATA_W-1:0] rd_data;

  // Next entry: flush beats stall; a flushed entry keeps stale data fields.
  always_comb begin
    memwb_d = memwb_q;
    if (wb.flush_i) begin
      memwb_d.valid    = 1'b0;
      memwb_d.regwrite = 1'b0;
    end else if (!wb.stall_i) begin
      memwb_d.valid    = wb.valid_i;
      memwb_d.regwrite = wb.RegWrite_i;
      memwb_d.memtoreg = wb.MemtoReg_i;
      memwb_d.rd       = wb.RDaddr_i;
      memwb_d.alu      = wb.ALUdata_i;
      memwb_d.mem      = wb.MEMdata_i;
    end
  end

  // MEM/WB register; async reset drops the write enable immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  // Write port decode; writes to r0 are suppressed.
  always_comb begin
    reg_we  = memwb_q.valid & memwb_q.regwrite & (memwb_q.rd != ZERO_REG);
    rd_data = memwb_q.memtoreg ? memwb_q.mem : memwb_q.alu;
  end

  // An entry retires on the first unstalled edge; stalled rewrites are not recounted.
  always_comb begin
    cnt_d = cnt_q;
    if (reg_we && !wb.stall_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Committed-write counter, wraps naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wb.RegWrite_o = reg_we;
  assign wb.RDaddr_o   = memwb_q.rd;
  assign wb.RDdata_o   = rd_data;
  assign wb.wb_count_o = cnt_q;

  wb_bypass u_bypass_rs (
    .we_i      (reg_we),
    .wr_addr_i (memwb_q.rd),
    .wr_data_i (rd_data),
    .rd_addr_i (wb.RSaddr_i),
    .rd_data_i (wb.RSdata_i),
    .rd_data_o (wb.RSdata_o)
  );

  wb_bypass u_bypass_rt (
    .we_i      (reg_we),
    .wr_addr_i (memwb_q.rd),
    .wr_data_i (rd_data),
    .rd_addr_i (wb.RTaddr_i),
    .rd_data_i (wb.RTdata_i),
    .rd_data_o (wb.RTdata_o)
  );

endmodule
